// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: follows incoming hsync/vsync, regenerates the
// pixel/line counters one clock behind the source and verifies the sync geometry.
module vga_sync_decoder #(
    parameter int unsigned H_ACTIVE     = 800,
    parameter int unsigned H_TOTAL      = 1056,
    parameter int unsigned H_SYNC_START = 840,
    parameter int unsigned H_SYNC_LEN   = 128,
    parameter int unsigned V_ACTIVE     = 600,
    parameter int unsigned V_TOTAL      = 628,
    parameter int unsigned V_SYNC_START = 601,
    parameter int unsigned V_SYNC_LEN   = 4,
    parameter int unsigned LOCK_FRAMES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hblnk,
    output logic        vblnk,
    output logic        locked,
    output logic        err,
    output logic [7:0]  err_count,
    output logic [10:0] meas_h_total,
    output logic [10:0] meas_v_total
);

    localparam logic [10:0] L_H_ACTIVE     = 11'(H_ACTIVE);
    localparam logic [10:0] L_H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] L_H_SYNC_START = 11'(H_SYNC_START);
    localparam logic [10:0] L_H_SYNC_LEN   = 11'(H_SYNC_LEN);
    localparam logic [10:0] L_V_ACTIVE     = 11'(V_ACTIVE);
    localparam logic [10:0] L_V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] L_V_TOTAL      = 11'(V_TOTAL);
    localparam logic [10:0] L_V_SYNC_START = 11'(V_SYNC_START);
    localparam logic [10:0] L_V_SYNC_LEN   = 11'(V_SYNC_LEN);
    localparam logic [10:0] L_MEAS_MAX     = 11'd2047;
    localparam logic [11:0] L_H_TOTAL_P    = 12'(H_TOTAL);
    localparam logic [11:0] L_H_TIMEOUT    = 12'(2 * H_TOTAL);
    localparam logic [7:0]  L_LOCK         = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      r_state, w_stateNext;
    logic        r_hsyncQ, r_vsyncQ;
    logic        w_hRise, w_hFall, w_vRise, w_vFall, w_hWrap;
    logic [10:0] w_hNext, w_vNext;
    logic [11:0] r_hPer;
    logic [10:0] r_hWid, r_vPer, r_vWid;
    logic        r_hArmed, r_vArmed, w_clearArm;
    logic        w_hPerBad, w_hWidBad, w_vPerBad, w_vWidBad, w_timeout, w_fail;
    logic [7:0]  r_good, w_goodNext;
    logic        r_frameBad, w_frameBadNext, w_errNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsyncQ <= 1'b0;
            r_vsyncQ <= 1'b0;
        end else begin
            r_hsyncQ <= hsync_in;
            r_vsyncQ <= vsync_in;
        end
    end

    assign w_hRise = hsync_in & ~r_hsyncQ;
    assign w_hFall = ~hsync_in & r_hsyncQ;
    assign w_vRise = vsync_in & ~r_vsyncQ;
    assign w_vFall = ~vsync_in & r_vsyncQ;
    assign w_hWrap = ~w_hRise && (hcount >= L_H_LAST);

    always_comb begin
        w_hNext = hcount + 11'd1;
        w_vNext = vcount;
        if (w_hRise) begin
            w_hNext = L_H_SYNC_START;
        end else if (w_hWrap) begin
            w_hNext = 11'd0;
        end
        if (w_vRise) begin
            w_vNext = L_V_SYNC_START;
        end else if (w_hWrap) begin
            w_vNext = (vcount >= L_V_LAST) ? 11'd0 : vcount + 11'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount <= 11'd0;
            vcount <= 11'd0;
            hblnk  <= 1'b0;
            vblnk  <= 1'b0;
        end else begin
            hcount <= w_hNext;
            vcount <= w_vNext;
            hblnk  <= (w_hNext >= L_H_ACTIVE);
            vblnk  <= (w_vNext >= L_V_ACTIVE);
        end
    end

    // h_per carries one extra bit so the 2*H_TOTAL timeout stays reachable even
    // though the reported period saturates at 2047.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hPer       <= 12'd0;
            r_hWid       <= 11'd0;
            r_vPer       <= 11'd0;
            r_vWid       <= 11'd0;
            meas_h_total <= 11'd0;
            meas_v_total <= 11'd0;
        end else begin
            if (w_hRise) begin
                r_hPer       <= 12'd1;
                meas_h_total <= (r_hPer > {1'b0, L_MEAS_MAX}) ? L_MEAS_MAX : r_hPer[10:0];
            end else if (r_hPer != 12'hFFF) begin
                r_hPer <= r_hPer + 12'd1;
            end
            if (w_hRise) begin
                r_hWid <= 11'd1;
            end else if (hsync_in && r_hWid != L_MEAS_MAX) begin
                r_hWid <= r_hWid + 11'd1;
            end
            if (w_vRise) begin
                r_vPer       <= {10'd0, w_hRise};
                meas_v_total <= r_vPer;
            end else if (w_hRise && r_vPer != L_MEAS_MAX) begin
                r_vPer <= r_vPer + 11'd1;
            end
            if (w_vRise) begin
                r_vWid <= {10'd0, w_hRise};
            end else if (vsync_in && w_hRise && r_vWid != L_MEAS_MAX) begin
                r_vWid <= r_vWid + 11'd1;
            end
        end
    end

    assign w_hPerBad  = r_hArmed && w_hRise && (r_hPer != L_H_TOTAL_P);
    assign w_hWidBad  = r_hArmed && w_hFall && (r_hWid != L_H_SYNC_LEN);
    assign w_vPerBad  = r_vArmed && w_vRise && (r_vPer != L_V_TOTAL);
    assign w_vWidBad  = r_vArmed && w_vFall && (r_vWid != L_V_SYNC_LEN);
    assign w_timeout  = r_hArmed && !w_hRise && (r_hPer == L_H_TIMEOUT);
    assign w_fail     = w_hPerBad | w_hWidBad | w_vPerBad | w_vWidBad | w_timeout;
    assign w_clearArm = (r_state == LOCKED) && w_fail;

    // Arming restarts from scratch whenever a locked decoder falls back to SEARCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hArmed <= 1'b0;
            r_vArmed <= 1'b0;
        end else if (w_clearArm) begin
            r_hArmed <= 1'b0;
            r_vArmed <= 1'b0;
        end else begin
            if (w_hRise) r_hArmed <= 1'b1;
            if (w_vRise) r_vArmed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SEARCH;
            r_good     <= 8'd0;
            r_frameBad <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_good     <= w_goodNext;
            r_frameBad <= w_frameBadNext;
        end
    end

    // A frame is judged at the vsync rise that closes it, including any check
    // failing on that very edge.
    always_comb begin
        w_stateNext    = r_state;
        w_goodNext     = r_good;
        w_frameBadNext = r_frameBad;
        w_errNext      = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_vRise && r_hArmed) begin
                    w_stateNext    = MEASURE;
                    w_goodNext     = 8'd0;
                    w_frameBadNext = 1'b0;
                end
            end
            MEASURE: begin
                if (w_vRise) begin
                    w_frameBadNext = 1'b0;
                    if (r_frameBad || w_fail) begin
                        w_goodNext = 8'd0;
                    end else begin
                        w_goodNext = r_good + 8'd1;
                        if (r_good + 8'd1 >= L_LOCK) w_stateNext = LOCKED;
                    end
                end else if (w_fail) begin
                    w_frameBadNext = 1'b1;
                end
            end
            LOCKED: begin
                if (w_fail) begin
                    w_stateNext = SEARCH;
                    w_errNext   = 1'b1;
                end
            end
            default: w_stateNext = SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= 8'd0;
        end else begin
            locked <= (w_stateNext == LOCKED);
            err    <= w_errNext;
            if (w_errNext && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a reduced-geometry sync source drives the decoder,
// expected events go into queues and a negedge monitor checks them.
module tb_vga_sync_decoder;

    localparam int HA  = 5;
    localparam int HT  = 8;
    localparam int HSS = 5;
    localparam int HSL = 2;
    localparam int VA  = 3;
    localparam int VT  = 5;
    localparam int VSS = 3;
    localparam int VSL = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync_in, vsync_in;
    logic [10:0] hcount, vcount, meas_h_total, meas_v_total;
    logic        hblnk, vblnk, locked, err;
    logic [7:0]  err_count;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hcount(hcount), .vcount(vcount), .hblnk(hblnk), .vblnk(vblnk),
        .locked(locked), .err(err), .err_count(err_count),
        .meas_h_total(meas_h_total), .meas_v_total(meas_v_total)
    );

    always #5 clk = ~clk;

    typedef struct { int h; int v; bit hb; bit vb; } trackExp_t;
    typedef struct { int cnt; bit chkMeas; int measH; } errExp_t;
    typedef struct { bit chkRises; int rises; int cnt; int measH; int measV; } lockExp_t;

    trackExp_t trackQ[$];
    errExp_t   errQ[$];
    lockExp_t  lockQ[$];

    int passCnt = 0;
    int totalCnt = 0;
    int gH, gV, vRiseCnt, expErr;
    bit hKill, stretchReq, vwExtra, cmpEn, prevVs, prevLocked;

    task automatic checkOutput(input string name, input int actual, input int expected);
        totalCnt++;
        if (actual == expected) passCnt++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_hcount"}, hcount, 0);
        checkOutput({tag, "_vcount"}, vcount, 0);
        checkOutput({tag, "_blnk"}, {hblnk, vblnk}, 0);
        checkOutput({tag, "_locked_err"}, {locked, err}, 0);
        checkOutput({tag, "_err_count"}, err_count, 0);
        checkOutput({tag, "_meas_h"}, meas_h_total, 0);
        checkOutput({tag, "_meas_v"}, meas_v_total, 0);
    endtask

    // Sync source: hsync high for HSL clocks from HSS, vsync high from line VSS.
    task automatic applyStimulus();
        bit hs, vs;
        int vw;
        vw = VSL + (vwExtra ? 1 : 0);
        hs = (gH >= HSS) && (gH < HSS + HSL) && !hKill;
        vs = (gV >= VSS) && (gV < VSS + vw);
        if (vs && !prevVs) vRiseCnt++;
        if (!vs && prevVs) vwExtra = 1'b0;
        prevVs   = vs;
        hsync_in = hs;
        vsync_in = vs;
    endtask

    task automatic genCycle();
        @(posedge clk);
        #1;
        if (cmpEn) trackQ.push_back('{gH, gV, gH >= HA, gV >= VA});
        if (gH == HT - 1) begin
            if (stretchReq) begin
                stretchReq = 1'b0;
            end else begin
                gH = 0;
                gV = (gV == VT - 1) ? 0 : gV + 1;
            end
        end else begin
            gH++;
        end
        applyStimulus();
    endtask

    task automatic waitGen(input int v, input int h);
        int n = 0;
        while (!(gV == v && gH == h) && n < 200) begin
            genCycle();
            n++;
        end
    endtask

    task automatic waitLockState(input bit want, input int bound, input string name, output bit ok);
        int n = 0;
        while (locked !== want && n < bound) begin
            genCycle();
            n++;
        end
        checkOutput(name, int'(locked), int'(want));
        ok = (locked === want);
    endtask

    always @(negedge clk) begin
        if (trackQ.size() > 0) begin
            trackExp_t t;
            t = trackQ.pop_front();
            checkOutput("track_hcount", hcount, t.h);
            checkOutput("track_vcount", vcount, t.v);
            checkOutput("track_hblnk", hblnk, t.hb);
            checkOutput("track_vblnk", vblnk, t.vb);
        end
        if (err === 1'b1) begin
            if (errQ.size() == 0) begin
                checkOutput("unexpected_err", 1, 0);
            end else begin
                errExp_t e;
                e = errQ.pop_front();
                checkOutput("err_count_at_err", err_count, e.cnt);
                checkOutput("locked_at_err", locked, 0);
                if (e.chkMeas) checkOutput("meas_h_at_err", meas_h_total, e.measH);
            end
        end
        if (locked === 1'b1 && !prevLocked) begin
            if (lockQ.size() == 0) begin
                checkOutput("unexpected_lock", 1, 0);
            end else begin
                lockExp_t l;
                l = lockQ.pop_front();
                if (l.chkRises) checkOutput("lock_vsync_rises", vRiseCnt, l.rises);
                checkOutput("err_count_at_lock", err_count, l.cnt);
                checkOutput("meas_h_at_lock", meas_h_total, l.measH);
                checkOutput("meas_v_at_lock", meas_v_total, l.measV);
            end
        end
        prevLocked = (locked === 1'b1);
    end

    initial begin
        bit ok1, ok2;
        rst = 1'b1;
        gH = 0; gV = 0; vRiseCnt = 0; expErr = 0;
        hKill = 0; stretchReq = 0; vwExtra = 0; cmpEn = 0; prevVs = 0; prevLocked = 0;
        applyStimulus();
        genCycle();
        genCycle();
        checkAllZero("reset");

        // Nominal timing from reset: lock on the third vsync rise.
        rst = 1'b0;
        vRiseCnt = 0;
        lockQ.push_back('{1'b1, 3, 0, HT, VT});
        waitLockState(1'b1, 400, "lock_nominal", ok1);

        // Two full frames of counter tracking, one clock behind the source.
        cmpEn = 1'b1;
        repeat (2 * HT * VT) genCycle();
        cmpEn = 1'b0;

        // One stretched line while locked.
        waitGen(0, 0);
        stretchReq = 1'b1;
        vRiseCnt = 0;
        expErr = 1;
        errQ.push_back('{1, 1'b1, HT + 1});
        lockQ.push_back('{1'b1, 3, 1, HT, VT});
        waitLockState(1'b0, 40, "unlock_stretch", ok1);
        waitLockState(1'b1, 400, "relock_stretch", ok2);

        // hsync missing for three lines: timeout.
        waitGen(0, 0);
        hKill = 1'b1;
        vRiseCnt = 0;
        expErr = 2;
        errQ.push_back('{2, 1'b0, 0});
        lockQ.push_back('{1'b1, 4, 2, HT, VT});
        repeat (3 * HT) genCycle();
        hKill = 1'b0;
        checkOutput("unlock_timeout", locked, 0);
        waitLockState(1'b1, 600, "relock_timeout", ok2);

        // Asynchronous reset in the middle of a locked frame.
        waitGen(1, 2);
        #3;
        rst = 1'b1;
        #1;
        checkAllZero("midreset");
        genCycle();
        genCycle();
        rst = 1'b0;
        vRiseCnt = 0;
        expErr = 0;
        lockQ.push_back('{1'b1, 3, 0, HT, VT});
        waitLockState(1'b1, 400, "relock_reset", ok2);

        // Over-wide vsync during MEASURE delays lock by one frame.
        waitGen(0, 0);
        rst = 1'b1;
        genCycle();
        rst = 1'b0;
        vwExtra = 1'b1;
        vRiseCnt = 0;
        lockQ.push_back('{1'b1, 4, 0, HT, VT});
        waitLockState(1'b1, 600, "lock_wide_vsync", ok2);

        // Force 260 errors; the counter must stick at 255.
        for (int i = 1; i <= 260; i++) begin
            waitGen(0, 0);
            stretchReq = 1'b1;
            vRiseCnt = 0;
            expErr = (i > 255) ? 255 : i;
            errQ.push_back('{expErr, 1'b1, HT + 1});
            lockQ.push_back('{1'b1, 3, expErr, HT, VT});
            waitLockState(1'b0, 40, "unlock_sat", ok1);
            waitLockState(1'b1, 400, "relock_sat", ok2);
            if (!ok1 || !ok2) break;
        end
        genCycle();
        genCycle();
        checkOutput("err_count_saturated", err_count, 255);
        checkOutput("err_queue_drained", errQ.size(), 0);
        checkOutput("lock_queue_drained", lockQ.size(), 0);
        checkOutput("track_queue_drained", trackQ.size(), 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
